// File: rtl/n_bit_alu_seq.sv
// Registered N-bit ALU with valid/ready handshakes on input and result, plus status flags.
// Define ALU_MUL_EN to build the N-cycle unsigned shift-add multiplier for op 111.
module n_bit_alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] f_out,
  output logic [N-1:0] f_hi,
  output logic         c_out,
  output logic         V,
  output logic         Z,
  output logic         Nf,
  output logic [1:0]   state_dbg
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MUL_EN
    ,
    S_BUSY = 2'd2
`endif
  } state_t;

  state_t state, state_next;
  logic   accept;
  logic   is_mul;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_valid/operands must stay stable until accepted; results stay stable until out_ready.
  assign accept = in_valid & in_ready;

  // Single-cycle datapath; SUB reuses the adder with inverted b and a forced carry-in.
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N:0]   add_sum;
  logic         c_into_msb;
  logic [N-1:0] alu_f;
  logic         alu_c;
  logic         alu_v;
  logic         alu_z;
  logic         alu_n;

  assign add_b      = (op == OP_SUB) ? ~b : b;
  assign add_cin    = (op == OP_SUB) ? 1'b1 : c_in;
  assign add_sum    = {1'b0, a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign c_into_msb = a[N-1] ^ add_b[N-1] ^ add_sum[N-1];

  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_f = add_sum[N-1:0];
        alu_c = add_sum[N];
        alu_v = add_sum[N] ^ c_into_msb;
      end
      OP_AND: alu_f = a & b;
      OP_OR:  alu_f = a | b;
      OP_XOR: alu_f = a ^ b;
      OP_NOT: alu_f = ~a;
      OP_SHL: begin
        alu_f = {a[N-2:0], 1'b0};
        alu_c = a[N-1];
      end
      default: alu_f = '0;
    endcase
  end

  assign alu_z = (alu_f == '0);
  assign alu_n = alu_f[N-1];

`ifdef ALU_MUL_EN
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]   a_r;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mul_next;
  logic [N:0]     mul_sum;
  logic [CW-1:0]  cnt;

  // acc = {partial product, remaining multiplier bits}; one bit retired per cycle.
  assign mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_r} : {(N+1){1'b0}});
  assign mul_next = {mul_sum, acc[N-1:1]};
  assign is_mul   = (op == OP_MUL);
`else
  assign is_mul = 1'b0;
  assign f_hi   = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = is_mul ? state_t'(2'd2) : S_DONE;
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        if (cnt == '0) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_next = is_mul ? state_t'(2'd2) : S_DONE;
          else        state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
    state_dbg = state;
  end

  // Result and flag registers; loaded only on completion so they hold through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_out <= '0;
      c_out <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      Nf    <= 1'b0;
`ifdef ALU_MUL_EN
      f_hi  <= '0;
      a_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
`endif
    end else if (accept && !is_mul) begin
      f_out <= alu_f;
      c_out <= alu_c;
      V     <= alu_v;
      Z     <= alu_z;
      Nf    <= alu_n;
`ifdef ALU_MUL_EN
      f_hi  <= '0;
    end else if (accept) begin
      a_r <= a;
      acc <= {{N{1'b0}}, b};
      cnt <= CW'(N - 1);
    end else if (state == S_BUSY) begin
      acc <= mul_next;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        f_out <= mul_next[N-1:0];
        f_hi  <= mul_next[2*N-1:N];
        c_out <= |mul_next[2*N-1:N];
        V     <= 1'b0;
        Z     <= (mul_next == '0);
        Nf    <= mul_next[2*N-1];
      end
`endif
    end
  end

endmodule

// File: tb/tb_n_bit_alu_seq.sv
// Directed bench for n_bit_alu_seq at N=4: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_n_bit_alu_seq;
  localparam int N = 4;
  localparam int W = 2*N + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         c_in = 1'b0;
  logic [2:0]   op = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] f_out;
  logic [N-1:0] f_hi;
  logic         c_out;
  logic         V;
  logic         Z;
  logic         Nf;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  n_bit_alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .f_out(f_out), .f_hi(f_hi), .c_out(c_out), .V(V), .Z(Z), .Nf(Nf),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input logic [N-1:0] hi, input logic [N-1:0] lo,
                                      input logic c, input logic v, input logic z, input logic n);
    return {hi, lo, c, v, z, n};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %h with empty queue at %0t",
                 {f_hi, f_out, c_out, V, Z, Nf}, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({f_hi, f_out, c_out, V, Z, Nf} !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h at %0t",
                   {f_hi, f_out, c_out, V, Z, Nf}, e, $time);
        end
      end
    end
  end

  // Driver: present an op, wait (bounded) for in_ready, push expectation, complete handshake.
  task automatic issue(input logic [2:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb,
                       input logic ci, input logic [W-1:0] e, input bit push);
    int n;
    n = 0;
    op = o; a = aa; b = bb; c_in = ci; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1 at %0t", $time);
      in_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 16'(exp_q.size()), 16'd0);
  endtask

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, NOT_ = 3'b101, SHL = 3'b110, MUL = 3'b111;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", 16'({in_ready, out_valid, f_hi, f_out, c_out, V, Z, Nf}),
          16'({1'b1, 1'b0, 4'h0, 4'h0, 4'b0000}));

    // ADD with signed overflow; result valid right after the accepting edge
    out_ready = 1'b1;
    issue(ADD, 4'b0111, 4'b0001, 1'b0, pk(4'h0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    check("add_latency_out_valid", 16'(out_valid), 16'd1);

    // SUB equal operands, then borrow, then signed overflow
    issue(SUB, 4'b0011, 4'b0011, 1'b0, pk(4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
    issue(SUB, 4'b0000, 4'b0001, 1'b1, pk(4'h0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    issue(SUB, 4'b1000, 4'b0001, 1'b0, pk(4'h0, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    drain();

    // MUL
`ifdef ALU_MUL_EN
    issue(MUL, 4'b1111, 4'b1111, 1'b0, pk(4'b1110, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1);
    for (int i = 0; i < N; i++) begin
      check("mul_busy_in_ready", 16'(in_ready), 16'd0);
      check("mul_busy_out_valid", 16'(out_valid), 16'd0);
      @(posedge clk);
      #1;
    end
    check("mul_latency_out_valid", 16'(out_valid), 16'd1);
`else
    issue(MUL, 4'b1111, 4'b1111, 1'b0, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
    check("mul_disabled_out_valid", 16'(out_valid), 16'd1);
    check("mul_disabled_f_out_z", 16'({f_hi, f_out, Z}), 16'({4'h0, 4'h0, 1'b1}));
`endif
    drain();

    // Backpressure: hold ADD result while XOR waits, then accept XOR in the release cycle
    out_ready = 1'b0;
    issue(ADD, 4'b0101, 4'b0010, 1'b1, pk(4'h0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    op = XOR_; a = 4'b1010; b = 4'b0110; c_in = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_in_ready", 16'(in_ready), 16'd0);
      check("hold_outputs", 16'({out_valid, f_hi, f_out, c_out, V, Z, Nf}),
            16'({1'b1, 4'h0, 4'b1000, 4'b0101}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    exp_q.push_back(pk(4'h0, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("no_bubble_out_valid", 16'(out_valid), 16'd1);
    check("no_bubble_f_out", 16'(f_out), 16'(4'b1100));
    drain();

    // Reset while a result is held in DONE
    out_ready = 1'b0;
    issue(ADD, 4'b0011, 4'b0100, 1'b0, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_done", 16'({in_ready, out_valid, f_hi, f_out, c_out, V, Z, Nf}),
          16'({1'b1, 1'b0, 4'h0, 4'h0, 4'b0000}));
    out_ready = 1'b1;

`ifdef ALU_MUL_EN
    // Reset on the second BUSY cycle of a MUL
    issue(MUL, 4'b1111, 4'b1111, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_busy", 16'({in_ready, out_valid, f_hi, f_out, c_out, V, Z, Nf}),
          16'({1'b1, 1'b0, 4'h0, 4'h0, 4'b0000}));
`endif
    issue(ADD, 4'b0001, 4'b0001, 1'b0, pk(4'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();

    // SHL, then change operands while DONE is held
    out_ready = 1'b0;
    issue(SHL, 4'b1001, 4'b0000, 1'b0, pk(4'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    a = 4'b0110; b = 4'b1111; op = ADD; c_in = 1'b1;
    @(negedge clk);
    check("done_inputs_ignored", 16'({f_out, c_out, V, Z, Nf}), 16'({4'b0010, 4'b1000}));
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Back-to-back single-cycle ops with out_ready high
    issue(AND_, 4'b1100, 4'b1010, 1'b0, pk(4'h0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    issue(OR_,  4'b0101, 4'b0010, 1'b0, pk(4'h0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(NOT_, 4'b0101, 4'b1111, 1'b1, pk(4'h0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    issue(ADD,  4'b1111, 4'b0001, 1'b0, pk(4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
    issue(ADD,  4'b0010, 4'b0011, 1'b1, pk(4'h0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
